// File: rtl/icache_fill.sv
// icache_fill: direct-mapped instruction cache with a two-block fill.
// A miss fetches the missing block and the block that follows it in a
// single memory access. The two blocks go into adjacent lines, so
// sequential code that runs into the next block still hits.
module icache_fill #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 128,
  parameter int LINES      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [WORD_SIZE-1:0]  fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [WORD_SIZE-1:0]  fetch_inst,
  input  logic                  flush,
  output logic                  mem_rd,
  output logic [WORD_SIZE-1:0]  mem_addr,
  input  logic [BLOCK_SIZE-1:0] mem_out1,
  input  logic [BLOCK_SIZE-1:0] mem_out2
);

  localparam int WORDS     = BLOCK_SIZE / WORD_SIZE;
  localparam int BSEL_BITS = $clog2(WORD_SIZE / 8);
  localparam int WSEL_BITS = $clog2(WORDS);
  localparam int OFS_BITS  = $clog2(BLOCK_SIZE / 8);
  localparam int IDX_BITS  = $clog2(LINES);
  localparam int TAG_BITS  = WORD_SIZE - OFS_BITS - IDX_BITS;
  localparam logic [WORD_SIZE-1:0] BLOCK_BYTES = WORD_SIZE'(BLOCK_SIZE / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [WORD_SIZE-1:0]  req_addr;
  logic [LINES-1:0]      line_valid;
  logic [TAG_BITS-1:0]   line_tag  [LINES];
  logic [BLOCK_SIZE-1:0] line_data [LINES];

  // Fields of the pending request, and of the block that follows it.
  logic [IDX_BITS-1:0]   req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [WSEL_BITS-1:0]  req_wsel;
  logic [WORD_SIZE-1:0]  blk_base;
  logic [WORD_SIZE-1:0]  nxt_base;
  logic [IDX_BITS-1:0]   nxt_idx;
  logic [TAG_BITS-1:0]   nxt_tag;
  logic                  line_hit;
  logic [BLOCK_SIZE-1:0] hit_line;
  logic [WORD_SIZE-1:0]  sel_word;
  logic                  accept;
  logic                  unused_bits;

  assign req_idx  = req_addr[OFS_BITS +: IDX_BITS];
  assign req_tag  = req_addr[OFS_BITS+IDX_BITS +: TAG_BITS];
  assign req_wsel = req_addr[BSEL_BITS +: WSEL_BITS];
  assign blk_base = {req_addr[WORD_SIZE-1:OFS_BITS], {OFS_BITS{1'b0}}};
  // Following block; its address wraps into the next tag when idx is last.
  assign nxt_base = blk_base + BLOCK_BYTES;
  assign nxt_idx  = nxt_base[OFS_BITS +: IDX_BITS];
  assign nxt_tag  = nxt_base[OFS_BITS+IDX_BITS +: TAG_BITS];
  // Byte-within-word bits and the always-zero block offset are not used.
  assign unused_bits = ^{req_addr[BSEL_BITS-1:0], nxt_base[OFS_BITS-1:0]};

  assign line_hit = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
  assign hit_line = line_data[req_idx];
  assign accept   = fetch_req && fetch_ready;

  // Pick the requested word from the line; word 0 is in the top bits.
  always_comb begin
    // NOTE: default every combinational output first so that no path can infer a latch.
    sel_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (req_wsel == WSEL_BITS'(w)) begin
        sel_word = hit_line[BLOCK_SIZE-1-w*WORD_SIZE -: WORD_SIZE];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: a hit with a new request stays in CHECK for streaming.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (fetch_req) state_nxt = S_CHECK;
      S_CHECK: begin
        if (!line_hit)      state_nxt = S_WAIT;
        else if (fetch_req) state_nxt = S_CHECK;
        else                state_nxt = S_IDLE;
      end
      S_WAIT:  state_nxt = S_CHECK;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: a hit returns its word combinationally, a miss strobes memory once.
  always_comb begin
    fetch_ready = 1'b0;
    fetch_valid = 1'b0;
    fetch_inst  = '0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    unique case (state)
      S_IDLE:  fetch_ready = 1'b1;
      S_CHECK: begin
        if (line_hit) begin
          fetch_ready = 1'b1;
          fetch_valid = 1'b1;
          fetch_inst  = sel_word;
        end else begin
          mem_rd   = 1'b1;
          mem_addr = blk_base;
        end
      end
      default: ;
    endcase
  end

  // Capture the address of each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      req_addr <= '0;
    else if (accept) req_addr <= fetch_addr;
  end

  // Valid bits: flush wins over a fill landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_valid <= '0;
    end else if (flush) begin
      line_valid <= '0;
    end else if (state == S_WAIT) begin
      line_valid[req_idx] <= 1'b1;
      line_valid[nxt_idx] <= 1'b1;
    end
  end

  // Tag and data storage, written only by an unflushed fill.
  // NOTE: storage arrays have no reset; the valid bits alone decide whether a line holds data.
  always_ff @(posedge clk) begin
    if (state == S_WAIT && !flush) begin
      line_tag[req_idx]  <= req_tag;
      line_data[req_idx] <= mem_out1;
      line_tag[nxt_idx]  <= nxt_tag;
      line_data[nxt_idx] <= mem_out2;
    end
  end

endmodule

// File: tb/tb_icache_fill.sv
// tb_icache_fill: directed and random fetches checked against a model that
// tracks which memory block each line holds.
module tb_icache_fill;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fetch_req;
  logic [31:0]  fetch_addr;
  logic         fetch_ready;
  logic         fetch_valid;
  logic [31:0]  fetch_inst;
  logic         flush;
  logic         mem_rd;
  logic [31:0]  mem_addr;
  logic [127:0] mem_out1;
  logic [127:0] mem_out2;
  logic [31:0]  lat_addr = 32'h0;

  int n_total = 0;
  int n_bad   = 0;

  // Model: which block address (if any) each of the 8 lines holds.
  bit          mdl_valid [8];
  logic [31:0] mdl_blk   [8];

  icache_fill dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_inst (fetch_inst),
    .flush      (flush),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_out1   (mem_out1),
    .mem_out2   (mem_out2)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct word for every word address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5AC3, ~a[15:0]} ^ 32'h01234567;
  endfunction

  function automatic logic [127:0] blk_of(input logic [31:0] a);
    return {word_of(a), word_of(a + 4), word_of(a + 8), word_of(a + 12)};
  endfunction

  // Memory latches the read address; both blocks are then presented.
  always @(posedge clk) if (mem_rd) lat_addr <= mem_addr;
  always_comb begin
    mem_out1 = blk_of(lat_addr);
    mem_out2 = blk_of(lat_addr + 32'd16);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 8; i++) mdl_valid[i] = 1'b0;
  endtask

  // A miss brings in the block and the next sequential block.
  task automatic mdl_fill(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'hF;
    mdl_valid[(b >> 4) % 8]        = 1'b1;
    mdl_blk[(b >> 4) % 8]          = b;
    mdl_valid[((b + 16) >> 4) % 8] = 1'b1;
    mdl_blk[((b + 16) >> 4) % 8]   = b + 16;
  endtask

  // One fetch. With want_flush, flush is pulsed in the response cycle of a
  // hit, or in the memory-wait cycle of a miss.
  task automatic fetch(input logic [31:0] a, input bit want_flush);
    logic [31:0] b;
    bit hit, got;
    int fl, exp_lat, exp_rd, lat, n_rd;
    b       = a & ~32'hF;
    hit     = mdl_valid[(b >> 4) % 8] && (mdl_blk[(b >> 4) % 8] == b);
    fl      = want_flush ? (hit ? 1 : 2) : 0;
    exp_lat = hit ? 1 : ((fl == 2) ? 5 : 3);
    exp_rd  = hit ? 0 : ((fl == 2) ? 2 : 1);
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = a;
    check("ready_at_req", 32'(fetch_ready), 32'd1);
    @(posedge clk);
    lat  = 0;
    n_rd = 0;
    got  = 1'b0;
    while (!got && lat < 12) begin
      @(negedge clk);
      fetch_req = 1'b0;
      flush     = 1'b0;
      lat++;
      if (mem_rd) begin
        n_rd++;
        check("mem_addr", mem_addr, b);
      end else begin
        check("mem_addr_idle", mem_addr, 32'h0);
      end
      if (fetch_valid) begin
        got = 1'b1;
        check("inst", fetch_inst, word_of(a & ~32'h3));
      end
      if (lat == fl) flush = 1'b1;
    end
    if (!got) check("timeout_valid", 32'd0, 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("mem_rd_count", 32'(n_rd), 32'(exp_rd));
    if (flush) begin
      @(negedge clk);
      flush = 1'b0;
    end
    if (fl == 2) mdl_clear();
    if (!hit) mdl_fill(a);
    if (fl == 1) mdl_clear();
  endtask

  // Four back-to-back hits within one cached block.
  task automatic stream(input logic [31:0] base);
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = base;
    check("stream_ready0", 32'(fetch_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stream_valid", 32'(fetch_valid), 32'd1);
      check("stream_inst", fetch_inst, word_of(base + 32'(4 * k)));
      check("stream_ready", 32'(fetch_ready), 32'd1);
      check("stream_no_rd", 32'(mem_rd), 32'd0);
      if (k < 3) fetch_addr = base + 32'(4 * (k + 1));
      else       fetch_req  = 1'b0;
    end
  endtask

  // Miss, then assert reset while the fill is pending.
  task automatic reset_in_wait(input logic [31:0] a);
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(posedge clk);
    @(negedge clk);
    fetch_req = 1'b0;
    check("rd_before_rst", 32'(mem_rd), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(fetch_ready), 32'd1);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
  endtask

  initial begin
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    flush      = 1'b0;
    mdl_clear();
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(fetch_ready), 32'd1);
    check("reset_valid", 32'(fetch_valid), 32'd0);
    check("reset_inst", fetch_inst, 32'h0);
    check("reset_mem_rd", 32'(mem_rd), 32'd0);
    check("reset_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;

    fetch(32'h0000_0008, 1'b0);  // cold miss
    fetch(32'h0000_0014, 1'b0);  // prefetched block hits
    fetch(32'h0000_0070, 1'b0);  // idx 7 fill wraps to line 0
    fetch(32'h0000_0080, 1'b0);  // hits the wrapped line
    fetch(32'h0000_0000, 1'b0);  // conflict
    fetch(32'h0000_0080, 1'b0);  // evicted, misses again
    fetch(32'h0000_0200, 1'b1);  // flush during the memory wait
    fetch(32'h0000_0204, 1'b1);  // hit delivered in the flush cycle
    fetch(32'h0000_0208, 1'b0);  // misses after that flush
    fetch(32'h0000_0000, 1'b0);
    stream(32'h0000_0000);
    reset_in_wait(32'h0000_0340);
    fetch(32'h0000_0340, 1'b0);  // nothing kept from the abandoned fill

    for (int i = 0; i < 80; i++) begin
      fetch(32'($urandom_range(0, 127)) * 32'd4, $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_fill.md
ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, meaning fetch address and instruction width in bits.
REQ-002 The block SHALL have parameter BLOCK_SIZE, default 128, meaning cache line and memory block width in bits (4 words).
REQ-003 The block SHALL have parameter LINES, default 8, meaning number of direct-mapped lines.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port fetch_req, input, 1 bit, meaning the fetch stage requests an instruction.
REQ-007 The block SHALL have port fetch_addr, input, WORD_SIZE bits, meaning the byte address of the instruction (bits [1:0] ignored).
REQ-008 The block SHALL have port fetch_ready, output, 1 bit, meaning the request is accepted at this edge.
REQ-009 The block SHALL have port fetch_valid, output, 1 bit, meaning fetch_inst is valid this cycle.
REQ-010 The block SHALL have port fetch_inst, output, WORD_SIZE bits, meaning the returned instruction word.
REQ-011 The block SHALL have port flush, input, 1 bit, meaning invalidate all lines.
REQ-012 The block SHALL have port mem_rd, output, 1 bit, meaning instruction-memory read strobe.
REQ-013 The block SHALL have port mem_addr, output, WORD_SIZE bits, meaning the block-aligned memory address (bits [3:0] zero).
REQ-014 The block SHALL have ports mem_out1 and mem_out2, input, BLOCK_SIZE bits each, meaning the block at mem_addr and the block at mem_addr+16; byte 0 sits in bits [127:120].

Function
REQ-015 Address split SHALL be: word select [3:2], index [6:4], tag [31:7]; word 0 = line bits [127:96], word 3 = [31:0].
REQ-016 Per line, the block SHALL hold a valid bit, a 25-bit tag and a 128-bit data word.
REQ-017 FSM states SHALL be IDLE, CHECK, WAIT.
REQ-018 fetch_ready SHALL be 1 in IDLE, 1 in CHECK on a hit, 0 otherwise.
REQ-019 An accepted request (fetch_req & fetch_ready) SHALL register fetch_addr into req_addr and enter CHECK; with no acceptance, CHECK on a hit SHALL return to IDLE.
REQ-020 In CHECK on a hit (valid and tag match for req_addr), fetch_valid SHALL be 1 and fetch_inst the selected word combinationally, i.e. 1-cycle hit latency after acceptance; back-to-back hits SHALL sustain one instruction per cycle.
REQ-021 In CHECK on a miss, the block SHALL drive mem_rd=1 and mem_addr={req_addr[31:4],4'b0} for exactly one cycle and enter WAIT.
REQ-022 mem_rd and mem_addr SHALL be 0 in all other cycles.
REQ-023 In WAIT, the block SHALL sample mem_out1 into line idx (tag of req_addr) and mem_out2 into line (idx+1) mod LINES with the tag of req_addr+16 (tag+1 when idx=7), set both valid, then re-enter CHECK, which then hits.
REQ-024 Miss latency SHALL be 3 cycles from acceptance to fetch_valid.
REQ-025 fetch_valid SHALL be 0 in IDLE and WAIT.
REQ-026 flush SHALL clear all valid bits at the next edge and take priority over a WAIT fill (fill discarded, CHECK misses and re-requests).
REQ-027 A hit response in the flush cycle SHALL still be delivered.
REQ-028 fetch_addr and fetch_req SHALL be ignored while fetch_ready=0; the requester holds them.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, all valid bits=0, req_addr=0, fetch_valid=0, fetch_inst=0, mem_rd=0, mem_addr=0, fetch_ready=1.
REQ-030 Reset mid-WAIT SHALL abandon the fill with no line written; after release the first request misses.

Verification
REQ-031 Cold miss: req 0x00000008 after reset -> mem_rd=1, mem_addr=0x00000000 one cycle; fetch_valid 3 cycles after acceptance with word 2 of mem_out1.
REQ-032 Prefetch: after REQ-031, req 0x00000014 -> hit, 1-cycle latency, word 1 of mem_out2, no mem_rd.
REQ-033 Wrap: req 0x00000070 (idx 7) miss -> line 0 filled with tag 1; then req 0x00000080 -> hit.
REQ-034 Conflict: req 0x00000000 then 0x00000080 -> second misses, evicts, mem_addr=0x00000080.
REQ-035 Flush during WAIT -> no fill kept; CHECK re-issues mem_rd with same mem_addr; response correct.
REQ-036 Streaming hits 0x0,0x4,0x8,0xC -> fetch_valid high 4 consecutive cycles, fetch_ready never drops.
